// File: rtl/iter_rshift.sv
// iter_rshift: multi-cycle right shifter, one bit position per clock.
// Logical (zero fill) or arithmetic (sign fill) shift of a WIDTH-bit operand
// by 0..WIDTH-1 positions. WIDTH must equal 2**SHW.
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0
// (IDLE or DONE state); num/shamt/arith are captured on that edge only.
// busy is high for exactly shamt cycles while shifting, and start is ignored
// throughout. done is a one-cycle pulse and result is valid in that cycle.
// result then holds until the next completion or reset.
module iter_rshift #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] ZERO = {SHW{1'b0}};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   count;
  logic             fill_flag;
  logic             accept;
  logic             last_shift;

  // A request is only taken while not shifting.
  assign accept     = start && (state != S_SHIFT);
  // count==1 before the edge marks the final shift of the operation.
  assign last_shift = (state == S_SHIFT) && (count == ONE);
  assign state_dbg  = state;

  // One-position right shift of the work register with the captured fill mode.
  always_comb begin
    shifted = {fill_flag & work[WIDTH-1], work[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded busy/done.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          state_nxt = (shamt == ZERO) ? S_DONE : S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (count == ONE) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, shift while in SHIFT, publish on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      count     <= '0;
      fill_flag <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      work      <= num;
      count     <= shamt;
      fill_flag <= arith;
      if (shamt == ZERO) begin
        result <= num;
      end
    end else if (state == S_SHIFT) begin
      work  <= shifted;
      count <= count - ONE;
      if (last_shift) begin
        result <= shifted;
      end
    end
  end

endmodule
